ldc_gate_arbiter: RTL
=====================

// Module: ldc_gate_arbiter
// PURPOSE
//   Shares one bank of WIDTH transparent D-latches with async clear among NREQ
//   requesters. Each requester asks for a write or a clear. The block grants
//   one requester at a time (round-robin) and sequences the bank's D/G/CLR pins
//   glitch-free: D is set up before G rises, G is held for a programmed width,
//   and D is held after G falls. It sits between the config/state writers and
//   the latch bank.
// PARAMETERS
//   NREQ      4  number of requesters (2..8)
//   WIDTH     8  latch bank data width
//   GATE_CYC  2  cycles LAT_G (or LAT_CLR) is held high (>=1)
//   GAP_CYC   1  hold cycles after gate/clear falls, D still driven (>=1)
// PORTS
//   C        in   1           clock, rising edge
//   R_N      in   1           reset, synchronous, active-low
//   REQ      in   NREQ        per-requester operation request, level
//   REQ_CLR  in   NREQ        1 = clear op, 0 = write op; sampled with REQ
//   DIN      in   NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//   GNT      out  NREQ        one-hot grant, high for the whole operation
//   DONE     out  NREQ        one-cycle completion pulse for the granted requester
//   BUSY     out  1           high in any state other than IDLE
//   LAT_D    out  WIDTH       registered data to the latch bank D pins
//   LAT_G    out  1           registered gate to the latch bank G pin
//   LAT_CLR  out  1           registered clear to the latch bank CLR pin
// BEHAVIOUR
//   - Reset: all outputs are 0 at the first edge with R_N low, also mid-operation.
//     FSM -> IDLE, round-robin pointer -> 0, counters -> 0.
//   - All outputs come from registers. LAT_G and LAT_CLR are never high together.
//   - FSM: IDLE -> SETUP -> GATE -> HOLD -> IDLE.
//     IDLE : if any REQ is high, pick the winner (round-robin, search starts at
//            ptr). Latch the winner's DIN and REQ_CLR, set GNT. Go to SETUP.
//     SETUP: 1 cycle. LAT_D = latched data (0 for a clear). G and CLR are low.
//     GATE : GATE_CYC cycles. LAT_G=1 for a write, LAT_CLR=1 for a clear.
//            LAT_D is held.
//     HOLD : GAP_CYC cycles. G and CLR are low, LAT_D is held.
//            DONE[winner]=1 in the last HOLD cycle. Next state is IDLE.
//            On that edge GNT clears and LAT_D returns to 0.
//   - Timing: REQ high at edge k gives GNT at k+1, LAT_G at k+2..k+1+GATE_CYC,
//     and DONE at k+1+GATE_CYC+GAP_CYC.
//     Occupancy is 2+GATE_CYC+GAP_CYC cycles per op, including the IDLE arbitration cycle.
//   - Round-robin: after a grant to i, ptr = (i+1) mod NREQ. Wrap NREQ-1 -> 0.
//   - Handshake: a requester drops REQ on the edge DONE is seen. If REQ is
//     still high in the following IDLE cycle, it is a new request.
//     Dropping REQ or changing DIN/REQ_CLR mid-op is ignored; the latched op
//     completes.
//   - Simultaneous REQs: resolved only in IDLE. Non-winners wait; no request is lost.
//   - Counters are $clog2(max(GATE_CYC,GAP_CYC))+1 bits wide and count down to 1.
// CONFIGURATION
//   LDC_ARB_PRIO0_EN defined: requester 0 beats round-robin whenever REQ[0]=1
//     in IDLE. Grants to 0 do not move ptr; others rotate as normal.
//   Not defined: pure round-robin for all NREQ requesters.
// TESTING (NREQ=4, WIDTH=8, GATE_CYC=2, GAP_CYC=1 unless noted)
//   1. R_N=0 for 2 cycles during GATE of a write -> next edge: LAT_G=0,
//      GNT=0, BUSY=0, LAT_D=00; the first grant after reset goes to the lowest requester.
//   2. REQ=0001, DIN[7:0]=A5 at edge 0 -> GNT=0001 at cycles 1-4, LAT_D=A5 at
//      cycles 1-4, LAT_G=1 at cycles 2-3, DONE=0001 at cycle 4, BUSY=0 at cycle 5.
//   3. REQ=0100, REQ_CLR=0100 -> LAT_CLR=1 for 2 cycles, LAT_G stays 0,
//      LAT_D=00, DONE=0100.
//   4. REQ=1111 held (each requester re-raises after DONE) -> grant order 0,1,2,3,0.
//      Each op is 5 cycles, with no overlap of GNT bits.
//   5. REQ[2] dropped and DIN[23:16] changed during GATE -> LAT_D keeps the
//      latched value; DONE[2] still pulses.
//   6. With LDC_ARB_PRIO0_EN, REQ=1110 then REQ[0] raised while 1 is served
//      -> next grant is 0, then 2.

Source files
------------

// File: rtl/ldc_gate_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ldc_gate_arbiter                                                |
// | Purpose  : Round-robin arbiter sequencing D/G/CLR of a shared latch bank.  |
// |            Optional LDC_ARB_PRIO0_EN gives requester 0 fixed priority.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ldc_gate_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int GATE_CYC = 2,
  parameter int GAP_CYC  = 1
) (
  input  logic                    C,
  input  logic                    R_N,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ-1:0]         REQ_CLR,
  input  logic [NREQ*WIDTH-1:0]   DIN,
  output logic [NREQ-1:0]         GNT,
  output logic [NREQ-1:0]         DONE,
  output logic                    BUSY,
  output logic [WIDTH-1:0]        LAT_D,
  output logic                    LAT_G,
  output logic                    LAT_CLR
);

  localparam int C_IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int C_MAXC = (GATE_CYC > GAP_CYC) ? GATE_CYC : GAP_CYC;
  localparam int C_CW   = $clog2(C_MAXC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GATE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [C_CW-1:0]   r_cnt;
  logic [C_IW-1:0]   r_ptr;
  logic              r_clr;

  logic [C_IW-1:0]   w_win;
  logic              w_any;
  logic              w_prio;
  logic [WIDTH-1:0]  w_din;
  logic [NREQ-1:0]   w_onehot;
  logic [C_IW-1:0]   w_ptr_next;

  // Round-robin search from r_ptr; descending loop lets the nearest requester win.
  always_comb begin
    w_win  = '0;
    w_any  = |REQ;
    w_prio = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (REQ[(int'(r_ptr) + k) % NREQ]) begin
        w_win = C_IW'((int'(r_ptr) + k) % NREQ);
      end
    end
`ifdef LDC_ARB_PRIO0_EN
    if (REQ[0]) begin
      w_win  = '0;
      w_prio = 1'b1;
    end
`endif
  end

  always_comb begin
    w_din      = DIN[int'(w_win)*WIDTH +: WIDTH];
    w_onehot   = NREQ'(1) << w_win;
    w_ptr_next = (w_win == C_IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  end

  always_ff @(posedge C) begin
    if (!R_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_clr   <= 1'b0;
      GNT     <= '0;
      DONE    <= '0;
      BUSY    <= 1'b0;
      LAT_D   <= '0;
      LAT_G   <= 1'b0;
      LAT_CLR <= 1'b0;
    end else begin
      DONE <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_SETUP;
            GNT     <= w_onehot;
            BUSY    <= 1'b1;
            r_clr   <= REQ_CLR[w_win];
            LAT_D   <= REQ_CLR[w_win] ? '0 : w_din;
            if (!w_prio) begin
              r_ptr <= w_ptr_next;
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_GATE;
          r_cnt   <= C_CW'(GATE_CYC);
          LAT_G   <= ~r_clr;
          LAT_CLR <= r_clr;
        end
        ST_GATE: begin
          if (r_cnt == C_CW'(1)) begin
            r_state <= ST_HOLD;
            r_cnt   <= C_CW'(GAP_CYC);
            LAT_G   <= 1'b0;
            LAT_CLR <= 1'b0;
            if (GAP_CYC == 1) begin
              DONE <= GNT;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          // DONE is registered, so it is launched one edge before the last HOLD cycle ends.
          if (r_cnt == C_CW'(1)) begin
            r_state <= ST_IDLE;
            GNT     <= '0;
            BUSY    <= 1'b0;
            LAT_D   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == C_CW'(2)) begin
              DONE <= GNT;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
